mem_stage: RTL and testbench

Memory-access (MEM) stage of the in-order five-stage pipeline; the receiving end of the EXE→MEM handshake and of the data-SRAM read path. It latches each instruction that EXE hands over and collects the one-cycle-latency `data_sram_rdata` for loads. It aligns and sign- or zero-extends load data, then forwards the final result to WB. It also publishes a forwarding/hazard bundle to ID. A small read-data hold buffer keeps load data correct when WB stalls the stage, because EXE may re-issue SRAM reads while MEM is stalled.

---
 rtl/mem_stage.sv | 97 +++++++++
 tb/tb_mem_stage.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage of the five-stage pipeline: latches the EXE hand-off, aligns and extends load data,
// and forwards the result to WB and to ID. A hold buffer keeps load data valid across WB stalls.
module mem_stage #(
  parameter int ES2MS_LEN = 76,
  parameter int MS2WS_LEN = 70
) (
  input  logic                 clk,
  input  logic                 resetn,
  output logic                 ms_allowin,
  input  logic                 es2ms_valid,
  input  logic [ES2MS_LEN-1:0] es2ms_bus,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 ws_allowin,
  output logic                 ms2ws_valid,
  output logic [MS2WS_LEN-1:0] ms2ws_bus,
  output logic [37:0]          ms_rf_zip
);

  logic        ms_valid_q;
  logic        first_q;
  logic [31:0] rbuf_q;
  logic [4:0]  ld_op_q;
  logic        res_from_mem_q;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] alu_result_q;
  logic [31:0] pc_q;

  logic        ms_ready_go;
  logic        capture;
  logic        leave;
  logic [31:0] rd;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_val;
  logic [31:0] final_result;

  assign ms_ready_go = 1'b1;
  assign ms_allowin  = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms2ws_valid = ms_valid_q & ms_ready_go;
  assign capture     = es2ms_valid & ms_allowin;
  assign leave       = ms2ws_valid & ws_allowin;

  // NOTE: reset is synchronous, so it lives inside the clocked branch; sequential state uses <= only.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid_q     <= 1'b0;
      first_q        <= 1'b0;
      rbuf_q         <= '0;
      ld_op_q        <= '0;
      res_from_mem_q <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      alu_result_q   <= '0;
      pc_q           <= '0;
    end else begin
      if (ms_allowin) ms_valid_q <= es2ms_valid;
      first_q <= capture;
      // SRAM data is only valid in the first resident cycle; keep it if we cannot leave yet.
      if (ms_valid_q & first_q & ~leave) rbuf_q <= data_sram_rdata;
      if (capture) begin
        ld_op_q        <= es2ms_bus[75:71];
        res_from_mem_q <= es2ms_bus[70];
        rf_we_q        <= es2ms_bus[69];
        rf_waddr_q     <= es2ms_bus[68:64];
        alu_result_q   <= es2ms_bus[63:32];
        pc_q           <= es2ms_bus[31:0];
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    rd       = first_q ? data_sram_rdata : rbuf_q;
    sel_byte = rd[7:0];
    case (alu_result_q[1:0])
      2'd1:    sel_byte = rd[15:8];
      2'd2:    sel_byte = rd[23:16];
      2'd3:    sel_byte = rd[31:24];
      default: sel_byte = rd[7:0];
    endcase
    sel_half = alu_result_q[1] ? rd[31:16] : rd[15:0];

    // ld_op one-hot {ld_w, ld_b, ld_bu, ld_h, ld_hu}; all-zero falls through to a word load.
    load_val = rd;
    if (ld_op_q[3])      load_val = {{24{sel_byte[7]}}, sel_byte};
    else if (ld_op_q[2]) load_val = {24'h0, sel_byte};
    else if (ld_op_q[1]) load_val = {{16{sel_half[15]}}, sel_half};
    else if (ld_op_q[0]) load_val = {16'h0, sel_half};

    final_result = res_from_mem_q ? load_val : alu_result_q;
  end

  assign ms2ws_bus = {rf_we_q, rf_waddr_q, final_result, pc_q};
  assign ms_rf_zip = {rf_we_q & ms_valid_q, rf_waddr_q, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs change 1ns after posedge, outputs are checked at negedge.
module tb_mem_stage;

  localparam logic [4:0] LD_W  = 5'b10000;
  localparam logic [4:0] LD_B  = 5'b01000;
  localparam logic [4:0] LD_BU = 5'b00100;
  localparam logic [4:0] LD_H  = 5'b00010;
  localparam logic [4:0] LD_HU = 5'b00001;
  localparam logic [4:0] ALU   = 5'b00000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ms_allowin;
  logic        es2ms_valid;
  logic [75:0] es2ms_bus;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        ms2ws_valid;
  logic [69:0] ms2ws_bus;
  logic [37:0] ms_rf_zip;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ms_allowin      (ms_allowin),
    .es2ms_valid     (es2ms_valid),
    .es2ms_bus       (es2ms_bus),
    .data_sram_rdata (data_sram_rdata),
    .ws_allowin      (ws_allowin),
    .ms2ws_valid     (ms2ws_valid),
    .ms2ws_bus       (ms2ws_bus),
    .ms_rf_zip       (ms_rf_zip)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Present an instruction from EXE; res_from_mem is implied by a nonzero ld_op except for ALU ops.
  task automatic issue(input logic [4:0] op, input logic rfm, input logic [4:0] waddr,
                       input logic [31:0] alu, input logic [31:0] pc);
    es2ms_valid = 1'b1;
    es2ms_bus   = {op, rfm, 1'b1, waddr, alu, pc};
  endtask

  task automatic idle();
    es2ms_valid = 1'b0;
    es2ms_bus   = '0;
  endtask

  initial begin
    resetn          = 1'b0;
    ws_allowin      = 1'b1;
    data_sram_rdata = 32'h0;
    idle();

    // Reset
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    sample();
    check("rst_valid",   {69'h0, ms2ws_valid}, 70'h0);
    check("rst_bus",     ms2ws_bus, 70'h0);
    check("rst_zip",     {32'h0, ms_rf_zip}, 70'h0);
    check("rst_allowin", {69'h0, ms_allowin}, 70'h1);

    // ld.w
    tick(); issue(LD_W, 1'b1, 5'd5, 32'h0000_1000, 32'h1C00_0010);
    tick(); idle(); data_sram_rdata = 32'h8899_AABB;
    sample();
    check("ldw_valid", {69'h0, ms2ws_valid}, 70'h1);
    check("ldw_bus",   ms2ws_bus, {1'b1, 5'd5, 32'h8899_AABB, 32'h1C00_0010});
    check("ldw_zip",   {32'h0, ms_rf_zip}, {32'h0, 1'b1, 5'd5, 32'h8899_AABB});

    // Extension cases, back-to-back at one per cycle
    tick(); issue(LD_B, 1'b1, 5'd1, 32'h0000_2003, 32'h1C00_0100);
    tick(); issue(LD_BU, 1'b1, 5'd2, 32'h0000_2003, 32'h1C00_0104); data_sram_rdata = 32'h8011_2233;
    sample(); check("ldb_a3", {38'h0, ms2ws_bus[63:32]}, 70'hFFFF_FF80);
    tick(); issue(LD_H, 1'b1, 5'd3, 32'h0000_2002, 32'h1C00_0108);
    sample(); check("ldbu_a3", {38'h0, ms2ws_bus[63:32]}, 70'h0000_0080);
    check("b2b_valid", {69'h0, ms2ws_valid}, 70'h1);
    tick(); issue(LD_HU, 1'b1, 5'd4, 32'h0000_2000, 32'h1C00_010C);
    sample(); check("ldh_a2", {38'h0, ms2ws_bus[63:32]}, 70'hFFFF_8011);
    tick(); issue(LD_B, 1'b1, 5'd6, 32'h0000_2001, 32'h1C00_0110);
    sample(); check("ldhu_a0", {38'h0, ms2ws_bus[63:32]}, 70'h0000_2233);
    tick(); idle();
    sample(); check("ldb_a1", {38'h0, ms2ws_bus[63:32]}, 70'h0000_0022);
    check("ldb_a1_pc", {38'h0, ms2ws_bus[31:0]}, 70'h1C00_0110);

    // Bubble: no valid, no reported write
    tick();
    sample();
    check("bubble_valid", {69'h0, ms2ws_valid}, 70'h0);
    check("bubble_we",    {69'h0, ms_rf_zip[37]}, 70'h0);

    // Stall hold: WB blocks for three cycles while EXE offers an ALU op
    tick(); issue(LD_W, 1'b1, 5'd7, 32'h0000_3000, 32'h1C00_0200);
    tick(); issue(ALU, 1'b0, 5'd8, 32'h0000_1234, 32'h1C00_0204);
    ws_allowin = 1'b0; data_sram_rdata = 32'h1234_5678;
    sample();
    check("stall1_res",     {38'h0, ms2ws_bus[63:32]}, 70'h1234_5678);
    check("stall1_allowin", {69'h0, ms_allowin}, 70'h0);
    tick(); data_sram_rdata = 32'hDEAD_BEEF;
    sample();
    check("stall2_res",     {38'h0, ms2ws_bus[63:32]}, 70'h1234_5678);
    check("stall2_allowin", {69'h0, ms_allowin}, 70'h0);
    check("stall2_pc",      {38'h0, ms2ws_bus[31:0]}, 70'h1C00_0200);
    tick();
    sample();
    check("stall3_res",     {38'h0, ms2ws_bus[63:32]}, 70'h1234_5678);
    check("stall3_allowin", {69'h0, ms_allowin}, 70'h0);
    // Release: load leaves and the ALU op is captured in the same edge
    tick(); ws_allowin = 1'b1;
    sample();
    check("release_valid", {69'h0, ms2ws_valid}, 70'h1);
    check("release_bus",   ms2ws_bus, {1'b1, 5'd7, 32'h1234_5678, 32'h1C00_0200});
    check("release_allowin", {69'h0, ms_allowin}, 70'h1);
    tick(); idle(); data_sram_rdata = 32'hFFFF_FFFF;
    sample();
    check("alu_pass", ms2ws_bus, {1'b1, 5'd8, 32'h0000_1234, 32'h1C00_0204});
    tick();
    sample(); check("after_alu_valid", {69'h0, ms2ws_valid}, 70'h0);

    // Back-to-back ld.w / ALU / ld.b
    tick(); issue(LD_W, 1'b1, 5'd10, 32'h0000_4000, 32'h1C00_0300);
    tick(); issue(ALU, 1'b0, 5'd11, 32'h0000_5555, 32'h1C00_0304); data_sram_rdata = 32'hA1B2_C3D4;
    sample(); check("b2b_ldw", {38'h0, ms2ws_bus[63:32]}, 70'hA1B2_C3D4);
    tick(); issue(LD_B, 1'b1, 5'd12, 32'h0000_6002, 32'h1C00_0308); data_sram_rdata = 32'h0;
    sample(); check("b2b_alu", {38'h0, ms2ws_bus[63:32]}, 70'h0000_5555);
    tick(); idle(); data_sram_rdata = 32'h00F7_0000;
    sample(); check("b2b_ldb", {38'h0, ms2ws_bus[63:32]}, 70'hFFFF_FFF7);
    check("b2b_ldb_zip", {32'h0, ms_rf_zip}, {32'h0, 1'b1, 5'd12, 32'hFFFF_FFF7});
    tick();

    // Reset in the second stalled cycle
    tick(); issue(LD_W, 1'b1, 5'd9, 32'h0000_7000, 32'h1C00_0400);
    tick(); idle(); ws_allowin = 1'b0; data_sram_rdata = 32'hCAFE_F00D;
    sample(); check("rs_stall1", {38'h0, ms2ws_bus[63:32]}, 70'hCAFE_F00D);
    tick(); data_sram_rdata = 32'h0; resetn = 1'b0;
    tick(); resetn = 1'b1; ws_allowin = 1'b1;
    sample();
    check("rs_valid", {69'h0, ms2ws_valid}, 70'h0);
    check("rs_zip",   {32'h0, ms_rf_zip}, 70'h0);
    tick(); issue(LD_W, 1'b1, 5'd13, 32'h0000_7004, 32'h1C00_0500);
    tick(); idle(); data_sram_rdata = 32'h0BAD_CAFE;
    sample();
    check("rs_fresh", ms2ws_bus, {1'b1, 5'd13, 32'h0BAD_CAFE, 32'h1C00_0500});
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
